valu_issue_arbiter: RTL and testbench
=====================================

# valu_issue_arbiter

Issue controller that shares one fixed-latency vector logic unit (AND/OR/XOR, opSel 01/10/11) between two requesters. It round-robin arbitrates single beats, locks the grant for multi-beat bursts, and caps in-flight beats with a credit counter. A tag FIFO records which requester owns each in-flight beat so that unit results are steered back to that requester. It sits between the vector issue/sequencer stage and the logic unit inside the vALU.

## Interface
- DATA_WIDTH, 64, operand/result width
- ADDR_WIDTH, 32, destination address width
- OPSEL_WIDTH, 2, opcode width (01=and, 10=or, 11=xor)
- MAX_OUTSTANDING, 8, max in-flight beats; also tag FIFO depth; power of two ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- reqN_valid  in  1  requester N (N=0,1) beat valid
- reqN_ready  out  1  requester N beat accepted this cycle when valid&ready
- reqN_last  in  1  final beat of burst (1 for single beat)
- reqN_vec0, reqN_vec1  in  DATA_WIDTH  operands
- reqN_opSel  in  OPSEL_WIDTH  opcode
- reqN_addr  in  ADDR_WIDTH  destination address
- alu_valid  out  1  beat to unit
- alu_vec0, alu_vec1  out  DATA_WIDTH  operands to unit
- alu_opSel  out  OPSEL_WIDTH  opcode to unit
- alu_addr  out  ADDR_WIDTH  address to unit
- alu_out_valid  in  1  unit result valid (no backpressure)
- alu_out_vec  in  DATA_WIDTH  unit result
- alu_out_addr  in  ADDR_WIDTH  unit result address
- rspN_valid  out  1  result for requester N
- rsp_vec  out  DATA_WIDTH  result data (shared)
- rsp_addr  out  ADDR_WIDTH  result address (shared)
- busy  out  1  state==BURST or outstanding count != 0
- err  out  1  sticky: alu_out_valid received with tag FIFO empty

## Operation
- Registers: state {IDLE, BURST}, owner (1b), rr_ptr (1b, requester favoured next), outstanding count (0..MAX_OUTSTANDING), tag FIFO of 1-bit IDs.
- credit_ok = count < MAX_OUTSTANDING (strict; same-cycle retire does not free a credit).
- IDLE grant: only one valid → that one; both valid → rr_ptr. BURST grant: owner only; the other requester sees ready=0.
- reqN_ready = (grant==N) & reqN_valid & credit_ok & !rst (combinational). Ready is low when valid is low.
- Accepted beat (issue): push N to tag FIFO; count+1; rr_ptr ← ~N.
- Transitions: IDLE→BURST on issue with last=0, owner←N. BURST→IDLE on issue from owner with last=1. All other cases hold state. If the owner drops valid in BURST, state holds and nothing issues.
- Retire (alu_out_valid): pop tag; count−1. Simultaneous issue and retire leave count unchanged; FIFO push and pop are legal in the same cycle, including when full.
- Retire with empty FIFO: set err, no pop, count held at 0, no rsp.
- alu_* registered: the cycle after an issue they carry the accepted beat; otherwise alu_valid=0 and data/opSel/addr=0.
- rsp registered: the cycle after retire, rsp[tag]_valid=1 and rsp_vec/rsp_addr = unit result. Otherwise both rspN_valid=0 and rsp_vec/rsp_addr=0.

## Timing
- Reset: all outputs 0, state IDLE, rr_ptr=0 (req0 favoured), count=0, FIFO empty, err=0. Reset mid-burst discards the lock and all tags; the unit shares the same reset.
- Issue at cycle T → alu_valid at T+1 → unit result at T+1+L (L = unit latency) → rspN_valid at T+2+L.
- Throughput: one beat per cycle while credit_ok.
- Order: results return in issue order (FIFO). rsp order equals issue order.

## Test plan
- Single beat: req0 valid, last=1, vec0=F0F0, vec1=FF00, opSel=01, addr=0x10 → ready at T, alu_valid at T+1, rsp0_valid with vec=F000, addr=0x10 at T+2+L; rsp1_valid never asserts.
- Contention: both requesters hold single beats for 4 cycles → grants 0,1,0,1; rsp0/rsp1 alternate in the same order.
- Burst lock: req0 sends 3 beats (last on 3rd) while req1 is valid throughout → req1_ready=0 for the 3 burst cycles, req1 granted on the next cycle, state returns to IDLE.
- Credit: bench unit withholds results; 8 beats issue, then ready stays 0 with count=8. One retire → one more issue the cycle after. Simultaneous issue and retire at count=7 → count stays 7.
- Reset mid-burst (count=3) → next cycle all outputs 0, busy=0, req1 grantable immediately.
- Spurious alu_out_valid at idle → err=1 and stays 1 until rst; no rspN_valid.

Source files
------------

// File: rtl/valu_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// valu_issue_arbiter_if
// Requester, logic-unit and response bundle of the vALU issue arbiter.
// Revision: 1.0
// ============================================================================
interface valu_issue_arbiter_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 2
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic                   req0_last;
    logic [DATA_WIDTH-1:0]  req0_vec0;
    logic [DATA_WIDTH-1:0]  req0_vec1;
    logic [OPSEL_WIDTH-1:0] req0_opSel;
    logic [ADDR_WIDTH-1:0]  req0_addr;

    logic                   req1_valid;
    logic                   req1_ready;
    logic                   req1_last;
    logic [DATA_WIDTH-1:0]  req1_vec0;
    logic [DATA_WIDTH-1:0]  req1_vec1;
    logic [OPSEL_WIDTH-1:0] req1_opSel;
    logic [ADDR_WIDTH-1:0]  req1_addr;

    logic                   alu_valid;
    logic [DATA_WIDTH-1:0]  alu_vec0;
    logic [DATA_WIDTH-1:0]  alu_vec1;
    logic [OPSEL_WIDTH-1:0] alu_opSel;
    logic [ADDR_WIDTH-1:0]  alu_addr;

    logic                   alu_out_valid;
    logic [DATA_WIDTH-1:0]  alu_out_vec;
    logic [ADDR_WIDTH-1:0]  alu_out_addr;

    logic                   rsp0_valid;
    logic                   rsp1_valid;
    logic [DATA_WIDTH-1:0]  rsp_vec;
    logic [ADDR_WIDTH-1:0]  rsp_addr;

    logic                   busy;
    logic                   err;

    // Environment side: requesters, logic unit and response consumers
    modport master (
        output req0_valid, req0_last, req0_vec0, req0_vec1, req0_opSel, req0_addr,
        input  req0_ready,
        output req1_valid, req1_last, req1_vec0, req1_vec1, req1_opSel, req1_addr,
        input  req1_ready,
        input  alu_valid, alu_vec0, alu_vec1, alu_opSel, alu_addr,
        output alu_out_valid, alu_out_vec, alu_out_addr,
        input  rsp0_valid, rsp1_valid, rsp_vec, rsp_addr,
        input  busy, err
    );

    modport slave (
        input  req0_valid, req0_last, req0_vec0, req0_vec1, req0_opSel, req0_addr,
        output req0_ready,
        input  req1_valid, req1_last, req1_vec0, req1_vec1, req1_opSel, req1_addr,
        output req1_ready,
        output alu_valid, alu_vec0, alu_vec1, alu_opSel, alu_addr,
        input  alu_out_valid, alu_out_vec, alu_out_addr,
        output rsp0_valid, rsp1_valid, rsp_vec, rsp_addr,
        output busy, err
    );
endinterface
`default_nettype wire

// File: rtl/valu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// valu_issue_arbiter
// Shares one fixed-latency vector logic unit between two requesters with
// round-robin single beats, burst locking, credits and result steering.
// Revision: 1.0
// ============================================================================
module valu_issue_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int OPSEL_WIDTH     = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    valu_issue_arbiter_if.slave   bus
);
    localparam int PTR_W = (MAX_OUTSTANDING > 2) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   owner;
    logic                   owner_nxt;
    logic                   rr_ptr;
    logic [CNT_W-1:0]       count;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   err_q;

    logic                   grant;
    logic                   credit_ok;
    logic                   ready0;
    logic                   ready1;
    logic                   issue;
    logic                   issue_id;
    logic                   issue_last;
    logic                   fifo_empty;
    logic                   retire;

    logic                   alu_valid_q;
    logic [DATA_WIDTH-1:0]  alu_vec0_q;
    logic [DATA_WIDTH-1:0]  alu_vec1_q;
    logic [OPSEL_WIDTH-1:0] alu_opSel_q;
    logic [ADDR_WIDTH-1:0]  alu_addr_q;

    logic                   rsp0_valid_q;
    logic                   rsp1_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_vec_q;
    logic [ADDR_WIDTH-1:0]  rsp_addr_q;

    // Strict compare: a retire in the same cycle does not free a credit
    assign credit_ok  = (count < CNT_MAX);
    assign fifo_empty = (count == '0);
    assign retire     = bus.alu_out_valid & ~fifo_empty;

    always_comb begin
        grant = 1'b0;
        if (state == BURST) begin
            grant = owner;
        end else if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant = rr_ptr;
        end
    end

    assign ready0     = ~grant & bus.req0_valid & credit_ok & ~rst;
    assign ready1     =  grant & bus.req1_valid & credit_ok & ~rst;
    assign issue      = ready0 | ready1;
    assign issue_id   = ready1;
    assign issue_last = issue_id ? bus.req1_last : bus.req0_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (issue && !issue_last) begin
                    state_nxt = BURST;
                    owner_nxt = issue_id;
                end
            end
            BURST: begin
                if (issue && issue_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Credit counter and tag FIFO share one occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (issue) begin
                rr_ptr          <= ~issue_id;
                tag_mem[wr_ptr] <= issue_id;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (issue && !retire) begin
                count <= count + CNT_ONE;
            end else if (!issue && retire) begin
                count <= count - CNT_ONE;
            end
            if (bus.alu_out_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            alu_valid_q <= 1'b0;
            alu_vec0_q  <= '0;
            alu_vec1_q  <= '0;
            alu_opSel_q <= '0;
            alu_addr_q  <= '0;
        end else begin
            alu_valid_q <= 1'b1;
            alu_vec0_q  <= issue_id ? bus.req1_vec0  : bus.req0_vec0;
            alu_vec1_q  <= issue_id ? bus.req1_vec1  : bus.req0_vec1;
            alu_opSel_q <= issue_id ? bus.req1_opSel : bus.req0_opSel;
            alu_addr_q  <= issue_id ? bus.req1_addr  : bus.req0_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !retire) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_vec_q    <= '0;
            rsp_addr_q   <= '0;
        end else begin
            rsp0_valid_q <= ~tag_mem[rd_ptr];
            rsp1_valid_q <=  tag_mem[rd_ptr];
            rsp_vec_q    <= bus.alu_out_vec;
            rsp_addr_q   <= bus.alu_out_addr;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_valid  = alu_valid_q;
    assign bus.alu_vec0   = alu_vec0_q;
    assign bus.alu_vec1   = alu_vec1_q;
    assign bus.alu_opSel  = alu_opSel_q;
    assign bus.alu_addr   = alu_addr_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_vec    = rsp_vec_q;
    assign bus.rsp_addr   = rsp_addr_q;
    assign bus.busy       = (state == BURST) | ~fifo_empty;
    assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_valu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// tb_valu_issue_arbiter
// Randomized scoreboard bench with a transaction-level model and logic unit.
// Revision: 1.0
// ============================================================================
module tb_valu_issue_arbiter;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int OW = 2;
    localparam int MAXO = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    valu_issue_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(OW)) bus ();

    valu_issue_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(OW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [DW-1:0] v0;
        logic [DW-1:0] v1;
        logic [OW-1:0] op;
        logic [AW-1:0] addr;
        int            cyc;
    } beat_t;
    typedef struct {
        bit            id;
        logic [DW-1:0] res;
        logic [AW-1:0] addr;
        int            cyc;
    } rsp_t;
    typedef struct {
        logic [DW-1:0] res;
        logic [AW-1:0] addr;
        int            rel;
    } unit_t;

    beat_t exp_alu[$];
    rsp_t  inflight[$];
    rsp_t  rsp_q[$];
    unit_t unit_q[$];
    int    dut_log[$];

    bit locked, owner_m, rr_m, err_m;
    bit unit_hold, spurious;
    bit acc[2];
    int rem[2];
    int passed = 0;
    int total = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] logic_op(input logic [OW-1:0] op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (op)
            2'b01:   return a & b;
            2'b10:   return a | b;
            2'b11:   return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic set_req_f(input int n, input bit v, input bit last,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [OW-1:0] op, input logic [AW-1:0] addr);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_last = last; bus.req0_vec0 = a;
            bus.req0_vec1 = b;  bus.req0_opSel = op;  bus.req0_addr = addr;
        end else begin
            bus.req1_valid = v; bus.req1_last = last; bus.req1_vec0 = a;
            bus.req1_vec1 = b;  bus.req1_opSel = op;  bus.req1_addr = addr;
        end
    endtask

    task automatic set_req(input int n, input bit v, input bit last);
        set_req_f(n, v, last, {$urandom, $urandom}, {$urandom, $urandom},
                  OW'($urandom_range(1, 3)), $urandom);
    endtask

    // One clock: drive unit, predict arbitration, update model, advance to next negedge
    task automatic step();
        unit_t u;
        bit v0, v1, g, credit, er0, er1, id, last, was_empty;
        beat_t b;
        bus.alu_out_valid = 1'b0;
        bus.alu_out_vec   = '0;
        bus.alu_out_addr  = '0;
        if (rst) begin
            unit_q.delete();
        end else if (spurious) begin
            bus.alu_out_valid = 1'b1;
            bus.alu_out_vec   = {$urandom, $urandom};
            bus.alu_out_addr  = $urandom;
        end else if (!unit_hold && unit_q.size() > 0 && unit_q[0].rel <= cyc) begin
            u = unit_q.pop_front();
            bus.alu_out_valid = 1'b1;
            bus.alu_out_vec   = u.res;
            bus.alu_out_addr  = u.addr;
        end
        #1;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        credit = inflight.size() < MAXO;
        if (locked)        g = owner_m;
        else if (v0 && v1) g = rr_m;
        else               g = v1;
        er0 = !rst && v0 && !g && credit;
        er1 = !rst && v1 &&  g && credit;
        check(bus.req0_ready == er0, "req0_ready", 64'(bus.req0_ready), 64'(er0));
        check(bus.req1_ready == er1, "req1_ready", 64'(bus.req1_ready), 64'(er1));
        if (bus.req0_ready || bus.req1_ready) dut_log.push_back(int'(bus.req1_ready));
        acc[0] = er0;
        acc[1] = er1;
        if (rst) begin
            inflight.delete(); rsp_q.delete(); exp_alu.delete();
            locked = 0; owner_m = 0; rr_m = 0; err_m = 0;
        end else begin
            was_empty = (inflight.size() == 0);
            if (er0 || er1) begin
                id = er1;
                b.v0   = id ? bus.req1_vec0  : bus.req0_vec0;
                b.v1   = id ? bus.req1_vec1  : bus.req0_vec1;
                b.op   = id ? bus.req1_opSel : bus.req0_opSel;
                b.addr = id ? bus.req1_addr  : bus.req0_addr;
                b.cyc  = cyc + 1;
                last   = id ? bus.req1_last  : bus.req0_last;
                exp_alu.push_back(b);
                inflight.push_back('{id, logic_op(b.op, b.v0, b.v1), b.addr, 0});
                rr_m = !id;
                if (!locked && !last) begin locked = 1; owner_m = id; end
                else if (locked && last) locked = 0;
            end
            if (bus.alu_out_valid) begin
                if (was_empty) begin
                    err_m = 1;
                end else begin
                    rsp_t r;
                    r = inflight.pop_front();
                    r.cyc = cyc + 1;
                    rsp_q.push_back(r);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_reqs();
        set_req(0, 0, 1);
        set_req(1, 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        idle_reqs();
        unit_hold = 0;
        while ((inflight.size() != 0 || unit_q.size() != 0 || rsp_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        check(n < 100, "drain_timeout", 64'(inflight.size()), 64'd0);
        step();
    endtask

    // Monitor: checks unit-side beats and responses, and plays the logic unit
    always @(posedge clk) begin
        beat_t b;
        rsp_t  r;
        #1;
        if (bus.alu_valid) begin
            if (exp_alu.size() == 0) begin
                check(0, "alu_unexpected", 64'(bus.alu_addr), 64'd0);
            end else begin
                b = exp_alu.pop_front();
                check(bus.alu_vec0 == b.v0 && bus.alu_vec1 == b.v1 && bus.alu_opSel == b.op
                      && bus.alu_addr == b.addr && cyc == b.cyc,
                      "alu_beat", bus.alu_vec0 ^ bus.alu_vec1 ^ 64'(bus.alu_addr),
                      b.v0 ^ b.v1 ^ 64'(b.addr));
            end
            unit_q.push_back('{logic_op(bus.alu_opSel, bus.alu_vec0, bus.alu_vec1),
                               bus.alu_addr, cyc + LAT});
        end else begin
            check(bus.alu_vec0 == 0 && bus.alu_vec1 == 0 && bus.alu_opSel == 0 && bus.alu_addr == 0,
                  "alu_idle_zero", bus.alu_vec0 | bus.alu_vec1 | 64'(bus.alu_addr), 64'd0);
        end
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (rsp_q.size() == 0) begin
                check(0, "rsp_unexpected", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
            end else begin
                r = rsp_q.pop_front();
                check(!(bus.rsp0_valid && bus.rsp1_valid) && bus.rsp1_valid == r.id,
                      "rsp_id", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, r.id ? 64'd2 : 64'd1);
                check(bus.rsp_vec == r.res && bus.rsp_addr == r.addr && cyc == r.cyc,
                      "rsp_data", bus.rsp_vec, r.res);
            end
        end else begin
            check(bus.rsp_vec == 0 && bus.rsp_addr == 0, "rsp_idle_zero",
                  bus.rsp_vec | 64'(bus.rsp_addr), 64'd0);
        end
        check(bus.busy == (locked || inflight.size() != 0), "busy",
              64'(bus.busy), 64'(locked || inflight.size() != 0));
        check(bus.err == err_m, "err", 64'(bus.err), 64'(err_m));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        unit_hold = 0;
        spurious = 0;
        idle_reqs();
        bus.alu_out_valid = 0;
        bus.alu_out_vec = '0;
        bus.alu_out_addr = '0;
        @(negedge clk);
        step(); step();
        rst = 0;
        step();

        // Contention from reset: requester 0 favoured first
        dut_log.delete();
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 1); set_req(1, 1, 1); step();
        end
        check(dut_log.size() == 4 && dut_log[0] == 0 && dut_log[1] == 1 && dut_log[2] == 0
              && dut_log[3] == 1, "contention_order", 64'(dut_log.size()), 64'd4);
        drain();

        // Single beat: F0F0 & FF00 -> F000 at 0x10
        set_req_f(0, 1, 1, 64'hF0F0, 64'hFF00, 2'b01, 32'h10);
        set_req(1, 0, 1);
        step();
        drain();
        set_req(1, 1, 1); step();
        drain();

        // Burst lock by requester 0 with requester 1 waiting
        dut_log.delete();
        for (int i = 0; i < 4; i++) begin
            set_req(0, i < 3, i == 2); set_req(1, 1, 1); step();
        end
        check(dut_log.size() == 4 && dut_log[0] == 0 && dut_log[1] == 0 && dut_log[2] == 0
              && dut_log[3] == 1, "burst_lock_order", 64'(dut_log.size()), 64'd4);
        drain();

        // Credits: results withheld until the counter saturates
        unit_hold = 1;
        for (int i = 0; i < 12; i++) begin set_req(0, 1, 1); set_req(1, 1, 1); step(); end
        unit_hold = 0; step();
        unit_hold = 1; step(); step();
        idle_reqs(); unit_hold = 0; step();
        unit_hold = 1; step();
        set_req(0, 1, 1); set_req(1, 1, 1); unit_hold = 0; step();
        unit_hold = 1; set_req(0, 1, 1); set_req(1, 1, 1); step(); step();
        drain();

        // Reset in the middle of a locked burst
        unit_hold = 1;
        for (int i = 0; i < 3; i++) begin set_req(0, 1, 0); set_req(1, 0, 1); step(); end
        set_req(0, 1, 0); set_req(1, 1, 1); rst = 1; step();
        rst = 0; unit_hold = 0;
        set_req(0, 0, 1); set_req(1, 1, 1); step();
        drain();

        // Randomized traffic with random unit stalls and bursts
        rem[0] = 0; rem[1] = 0; acc[0] = 0; acc[1] = 0;
        for (int c = 0; c < 700; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) rem[n]--;
                if (rem[n] == 0 && $urandom_range(0, 2) == 0) rem[n] = $urandom_range(1, 3);
                set_req(n, rem[n] > 0 && $urandom_range(0, 9) != 0, rem[n] == 1);
            end
            unit_hold = ($urandom_range(0, 3) == 0);
            step();
        end
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) rem[n]--;
        end
        // Finish any open burst so the lock is released before draining
        while (locked && rem[owner_m] > 0) begin
            set_req(int'(owner_m), 1, rem[owner_m] == 1);
            set_req(int'(!owner_m), 0, 1);
            unit_hold = 0;
            step();
            if (acc[owner_m]) rem[owner_m]--;
        end
        drain();
        check(exp_alu.size() == 0 && rsp_q.size() == 0, "scoreboard_empty",
              64'(exp_alu.size() + rsp_q.size()), 64'd0);

        // Spurious result while idle: sticky error, no response
        spurious = 1; step();
        spurious = 0;
        for (int i = 0; i < 4; i++) step();
        rst = 1; step();
        rst = 0; step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
